rom_download_ctrl: RTL and testbench
====================================

Name: rom_download_ctrl

Overview:
- Front end of the ROM download path. Sits between the host download interface (ioctl bus) and the ROM-image address selector / dual-port ROM bank.
- Filters and qualifies ioctl writes, turns each accepted write into a single-cycle write pulse with registered address and data, and counts bytes.
- Accumulates a 16-bit checksum and validates the image size. Holds the game core in reset until a complete, valid image has loaded.

Parameters:
- ROM_INDEX, 8'd0, ioctl_index value that identifies the ROM image; downloads with any other index are ignored.
- ROM_SIZE, 25'h18500, expected total image length in bytes.
- CHECK_SUM, 1'b0, when 1 the final checksum must equal EXPECTED_SUM.
- EXPECTED_SUM, 16'h0000, expected modulo-2^16 byte sum of the image.
- RESET_HOLD, 16, number of CLK cycles core_reset stays high after load completes; minimum 1.

Ports:
- CLK  in  1  download/system clock.
- RESET  in  1  synchronous, active-high reset.
- ioctl_download  in  1  high while the host transfers a file.
- ioctl_index  in  8  file index of the current transfer.
- ioctl_wr  in  1  write strobe; may stay high for several cycles per byte.
- ioctl_addr  in  25  byte address of the current write.
- ioctl_dout  in  8  byte data of the current write.
- dl_addr  out  25  registered write address to the selector/ROMs.
- dl_data  out  8  registered write data.
- dl_wr  out  1  one-cycle write pulse.
- core_reset  out  1  high while the core must be held in reset.
- rom_loaded  out  1  high after a valid image has loaded.
- dl_error  out  2  {size_err, sum_err} from the last completed download.
- byte_count  out  25  number of bytes accepted in the current or last download.

Behaviour:
- Reset values: dl_addr=0, dl_data=0, dl_wr=0, core_reset=1, rom_loaded=0, dl_error=0, byte_count=0. Reset internal checksum and hold counter to 0; state goes to IDLE.
- active = ioctl_download & (ioctl_index==ROM_INDEX).
- Write edge detect: register ioctl_wr as wr_q. A write is accepted when ioctl_wr & ~wr_q & active & (ioctl_addr < ROM_SIZE).
  - A held strobe produces exactly one accept.
  - Writes at addr >= ROM_SIZE are not forwarded and set the overflow flag.
- Latency: on an accepted write at cycle N, dl_addr/dl_data carry the cycle-N ioctl values at cycle N+1, and dl_wr=1 for cycle N+1 only.
  - dl_addr and dl_data hold their values when no write is accepted.
- On each accept: byte_count += 1 and sum += ioctl_dout, with the sum truncated to 16 bits.
- States:
  - IDLE: core_reset=1. Rising edge of active -> LOAD; byte_count, sum, overflow and dl_error are cleared, and rom_loaded is cleared.
  - LOAD: forwards writes. Falling edge of active -> CHECK.
  - CHECK (1 cycle): size_err = overflow | (byte_count != ROM_SIZE). sum_err = CHECK_SUM & (sum != EXPECTED_SUM). No error -> HOLD; otherwise -> ERROR.
  - HOLD: core_reset=1. The counter counts RESET_HOLD cycles, then -> RUN.
  - RUN: core_reset=0, rom_loaded=1.
  - ERROR: core_reset=1, rom_loaded=0.
  - A new rising edge of active in RUN or ERROR -> LOAD. Entering LOAD re-asserts core_reset the next cycle.
- Index switch mid-transfer (ioctl_index changes while ioctl_download=1) is treated as a falling edge of active -> CHECK.
- ioctl_download pulses with other indices never affect state, outputs or counters.
- Simultaneous write accept and falling edge of active in the same cycle: the write is accepted and counted before CHECK evaluates. CHECK uses the updated count, so the sample is taken one cycle later.
- RESET asserted mid-download: return to IDLE with reset values. Subsequent writes are ignored until a fresh rising edge of active.
- byte_count saturates at 25'h1FFFFFF and never wraps. Duplicate addresses are counted, so a size mismatch is detected by count, not by coverage.

Test Plan:
- Full download of 0x18500 bytes with ioctl_index=0 and ioctl_wr held 3 cycles per byte -> exactly 0x18500 dl_wr pulses, each one cycle after its strobe rise. byte_count=0x18500, dl_error=0, core_reset falls exactly RESET_HOLD cycles after CHECK, rom_loaded=1.
- Short download of 0x18000 bytes -> dl_error=2'b10, core_reset stays 1, rom_loaded=0.
- Write at addr 0x18500 during download -> no dl_wr for that byte, dl_error=2'b10 at end.
- CHECK_SUM=1 with EXPECTED_SUM set 1 off from the true sum -> dl_error=2'b01. Correct EXPECTED_SUM -> dl_error=0 and RUN reached.
- Download with ioctl_index=1 while in RUN -> no dl_wr, rom_loaded stays 1, core_reset stays 0.
- RESET pulsed at byte 0x100 -> all outputs return to reset values. A following full valid download reaches RUN with byte_count=0x18500.

Source files
------------

// File: rtl/rom_download_ctrl.sv
// ============================================================================
//  Module   : rom_download_ctrl
//  Purpose  : Qualifies ioctl ROM writes, forwards them as one-cycle pulses,
//             checks image size/checksum and gates the core reset.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module rom_download_ctrl #(
    parameter logic [7:0]  ROM_INDEX    = 8'd0,
    parameter logic [24:0] ROM_SIZE     = 25'h18500,
    parameter logic        CHECK_SUM    = 1'b0,
    parameter logic [15:0] EXPECTED_SUM = 16'h0000,
    parameter int          RESET_HOLD   = 16
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic [24:0] dl_addr,
    output logic [7:0]  dl_data,
    output logic        dl_wr,
    output logic        core_reset,
    output logic        rom_loaded,
    output logic [1:0]  dl_error,
    output logic [24:0] byte_count
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_CHECK = 3'd2,
        ST_HOLD  = 3'd3,
        ST_RUN   = 3'd4,
        ST_ERROR = 3'd5
    } state_t;

    localparam int                  c_HOLD_W    = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
    localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(RESET_HOLD - 1);
    localparam logic [24:0]         c_COUNT_MAX = 25'h1FF_FFFF;

    state_t              r_state;
    logic                r_wr_q;
    logic                r_active_q;
    logic                r_overflow;
    logic [15:0]         r_sum;
    logic [24:0]         r_byte_count;
    logic [c_HOLD_W-1:0] r_hold_cnt;
    logic [24:0]         r_dl_addr;
    logic [7:0]          r_dl_data;
    logic                r_dl_wr;
    logic                r_core_reset;
    logic                r_rom_loaded;
    logic [1:0]          r_dl_error;

    logic w_active;
    logic w_wr_rise;
    logic w_in_range;
    logic w_restart;
    logic w_fall;
    logic w_take;
    logic w_accept;
    logic w_ovf;
    logic w_size_err;
    logic w_sum_err;

    assign w_active   = ioctl_download & (ioctl_index == ROM_INDEX);
    assign w_wr_rise  = ioctl_wr & ~r_wr_q;
    assign w_in_range = (ioctl_addr < ROM_SIZE);
    assign w_fall     = ~w_active & r_active_q;
    assign w_restart  = w_active & ~r_active_q &
                        ((r_state == ST_IDLE) | (r_state == ST_RUN) | (r_state == ST_ERROR));

    // A write arriving in the same cycle as the restart belongs to the new image.
    assign w_take     = w_wr_rise & w_active & ((r_state == ST_LOAD) | w_restart);
    assign w_accept   = w_take & w_in_range;
    assign w_ovf      = w_take & ~w_in_range;

    assign w_size_err = r_overflow | (r_byte_count != ROM_SIZE);
    assign w_sum_err  = CHECK_SUM & (r_sum != EXPECTED_SUM);

    // Active history resets high so an ongoing transfer cut by RESET is not
    // mistaken for a new one.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_wr_q     <= 1'b0;
            r_active_q <= 1'b1;
        end else begin
            r_wr_q     <= ioctl_wr;
            r_active_q <= w_active;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_dl_addr <= 25'd0;
            r_dl_data <= 8'd0;
            r_dl_wr   <= 1'b0;
        end else begin
            r_dl_wr <= w_accept;
            if (w_accept) begin
                r_dl_addr <= ioctl_addr;
                r_dl_data <= ioctl_dout;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_byte_count <= 25'd0;
            r_sum        <= 16'd0;
            r_overflow   <= 1'b0;
        end else if (w_restart) begin
            r_byte_count <= {24'd0, w_accept};
            r_sum        <= w_accept ? {8'd0, ioctl_dout} : 16'd0;
            r_overflow   <= w_ovf;
        end else begin
            if (w_accept && (r_byte_count != c_COUNT_MAX)) begin
                r_byte_count <= r_byte_count + 25'd1;
            end
            if (w_accept) begin
                r_sum <= r_sum + {8'd0, ioctl_dout};
            end
            if (w_ovf) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state      <= ST_IDLE;
            r_core_reset <= 1'b1;
            r_rom_loaded <= 1'b0;
            r_dl_error   <= 2'b00;
            r_hold_cnt   <= '0;
        end else if (w_restart) begin
            r_state      <= ST_LOAD;
            r_core_reset <= 1'b1;
            r_rom_loaded <= 1'b0;
            r_dl_error   <= 2'b00;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_core_reset <= 1'b1;
                end
                ST_LOAD: begin
                    r_core_reset <= 1'b1;
                    if (w_fall) begin
                        r_state <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    r_dl_error <= {w_size_err, w_sum_err};
                    r_hold_cnt <= '0;
                    r_state    <= (w_size_err | w_sum_err) ? ST_ERROR : ST_HOLD;
                end
                ST_HOLD: begin
                    // HOLD occupies exactly RESET_HOLD cycles.
                    if (r_hold_cnt == c_HOLD_LAST) begin
                        r_state      <= ST_RUN;
                        r_core_reset <= 1'b0;
                        r_rom_loaded <= 1'b1;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 1'b1;
                    end
                end
                ST_RUN: begin
                    r_core_reset <= 1'b0;
                    r_rom_loaded <= 1'b1;
                end
                ST_ERROR: begin
                    r_core_reset <= 1'b1;
                    r_rom_loaded <= 1'b0;
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_core_reset <= 1'b1;
                    r_rom_loaded <= 1'b0;
                end
            endcase
        end
    end

    assign dl_addr    = r_dl_addr;
    assign dl_data    = r_dl_data;
    assign dl_wr      = r_dl_wr;
    assign core_reset = r_core_reset;
    assign rom_loaded = r_rom_loaded;
    assign dl_error   = r_dl_error;
    assign byte_count = r_byte_count;

endmodule

`default_nettype wire

// File: tb/tb_rom_download_ctrl.sv
// ============================================================================
//  Module   : tb_rom_download_ctrl
//  Purpose  : Self-checking bench for rom_download_ctrl (scenario table plus
//             write scoreboard).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_rom_download_ctrl;

    // Reduced image keeps the run short; byte data is addr[7:0]^0xA5, so every
    // 256-byte block sums to 0x7F80 and 0x400 bytes sum to 0xFE00.
    localparam logic [24:0] c_ROM_SIZE = 25'h400;
    localparam int          c_RH       = 7;
    localparam logic [15:0] c_IMG_SUM  = 16'hFE00;

    logic        clk = 1'b0;
    logic        rst;
    logic        ioctl_download;
    logic [7:0]  ioctl_index;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;

    logic [24:0] dl_addr,    ok_addr,    bad_addr;
    logic [7:0]  dl_data,    ok_data,    bad_data;
    logic        dl_wr,      ok_wr,      bad_wr;
    logic        core_reset, ok_core,    bad_core;
    logic        rom_loaded, ok_loaded,  bad_loaded;
    logic [1:0]  dl_error,   ok_err,     bad_err;
    logic [24:0] byte_count, ok_count,   bad_count;

    always #5 clk = ~clk;

    rom_download_ctrl #(.ROM_INDEX(8'd0), .ROM_SIZE(c_ROM_SIZE), .CHECK_SUM(1'b0),
                        .EXPECTED_SUM(16'h0000), .RESET_HOLD(c_RH)) dut (
        .CLK(clk), .RESET(rst), .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
        .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
        .dl_addr(dl_addr), .dl_data(dl_data), .dl_wr(dl_wr), .core_reset(core_reset),
        .rom_loaded(rom_loaded), .dl_error(dl_error), .byte_count(byte_count));

    rom_download_ctrl #(.ROM_INDEX(8'd0), .ROM_SIZE(c_ROM_SIZE), .CHECK_SUM(1'b1),
                        .EXPECTED_SUM(c_IMG_SUM), .RESET_HOLD(c_RH)) dut_sum_ok (
        .CLK(clk), .RESET(rst), .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
        .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
        .dl_addr(ok_addr), .dl_data(ok_data), .dl_wr(ok_wr), .core_reset(ok_core),
        .rom_loaded(ok_loaded), .dl_error(ok_err), .byte_count(ok_count));

    rom_download_ctrl #(.ROM_INDEX(8'd0), .ROM_SIZE(c_ROM_SIZE), .CHECK_SUM(1'b1),
                        .EXPECTED_SUM(c_IMG_SUM + 16'd1), .RESET_HOLD(c_RH)) dut_sum_bad (
        .CLK(clk), .RESET(rst), .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
        .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
        .dl_addr(bad_addr), .dl_data(bad_data), .dl_wr(bad_wr), .core_reset(bad_core),
        .rom_loaded(bad_loaded), .dl_error(bad_err), .byte_count(bad_count));

    typedef struct {
        logic [24:0] addr;
        logic [7:0]  data;
        int          cyc;
    } sb_t;

    typedef struct {
        string       name;
        logic [7:0]  idx;
        int          nbytes;
        bit          ovf;
        bit          timed;
        bit          cs;
        logic [1:0]  exp_err;
        logic        exp_loaded;
        logic        exp_core_reset;
        logic [24:0] exp_count;
    } scen_t;

    sb_t   sb_q[$];
    scen_t tbl[5];
    int    cycle    = 0;
    int    checks   = 0;
    int    failures = 0;

    always @(posedge clk) cycle++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Every dl_wr pulse must match the oldest expected write, one cycle after its strobe rose.
    always @(negedge clk) begin
        sb_t e;
        if (dl_wr === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("dl_wr_unexpected", {31'd0, dl_wr}, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check("dl_addr", {7'd0, dl_addr}, {7'd0, e.addr});
                check("dl_data", {24'd0, dl_data}, {24'd0, e.data});
                check("dl_wr_latency", cycle, e.cyc + 1);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_byte(input logic [24:0] a, input bit fwd);
        logic [7:0] d;
        d          = a[7:0] ^ 8'hA5;
        ioctl_addr = a;
        ioctl_dout = d;
        ioctl_wr   = 1'b1;
        if (fwd) sb_q.push_back('{a, d, cycle});
        tick(); tick(); tick();
        ioctl_wr = 1'b0;
        tick();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_dl_addr"},    {7'd0, dl_addr},    32'd0);
        check({tag, "_dl_data"},    {24'd0, dl_data},   32'd0);
        check({tag, "_dl_wr"},      {31'd0, dl_wr},     32'd0);
        check({tag, "_core_reset"}, {31'd0, core_reset}, 32'd1);
        check({tag, "_rom_loaded"}, {31'd0, rom_loaded}, 32'd0);
        check({tag, "_dl_error"},   {30'd0, dl_error},  32'd0);
        check({tag, "_byte_count"}, {7'd0, byte_count}, 32'd0);
    endtask

    task automatic run_download(input scen_t s);
        bit fwd;
        int fall_cyc;
        int n;
        fwd            = (s.idx == 8'd0);
        ioctl_index    = s.idx;
        ioctl_download = 1'b1;
        tick();
        if (fwd) begin
            check({s.name, "_core_reset_in_load"}, {31'd0, core_reset}, 32'd1);
            check({s.name, "_rom_loaded_in_load"}, {31'd0, rom_loaded}, 32'd0);
        end
        for (int i = 0; i < s.nbytes; i++) wr_byte(25'(i), fwd);
        if (s.ovf) wr_byte(c_ROM_SIZE, 1'b0);
        ioctl_download = 1'b0;
        fall_cyc       = cycle;
        if (s.timed) begin
            // Fall sampled next edge -> CHECK, then HOLD for c_RH cycles, then RUN.
            n = 0;
            while (core_reset !== 1'b0 && n < c_RH + 20) begin
                tick();
                n++;
            end
            check({s.name, "_core_reset_fall_cycle"}, cycle, fall_cyc + 2 + c_RH);
        end
        repeat (c_RH + 5) tick();
        check({s.name, "_dl_error"},   {30'd0, dl_error},  {30'd0, s.exp_err});
        check({s.name, "_rom_loaded"}, {31'd0, rom_loaded}, {31'd0, s.exp_loaded});
        check({s.name, "_core_reset"}, {31'd0, core_reset}, {31'd0, s.exp_core_reset});
        check({s.name, "_byte_count"}, {7'd0, byte_count}, {7'd0, s.exp_count});
        check({s.name, "_sb_drained"}, sb_q.size(), 32'd0);
        if (s.cs) begin
            check({s.name, "_sum_ok_err"},    {30'd0, ok_err},    32'd0);
            check({s.name, "_sum_ok_loaded"}, {31'd0, ok_loaded}, 32'd1);
            check({s.name, "_sum_bad_err"},   {30'd0, bad_err},   32'd1);
            check({s.name, "_sum_bad_core"},  {31'd0, bad_core},  32'd1);
        end
    endtask

    initial begin
        tbl[0] = '{"full",      8'd0, 1024, 1'b0, 1'b1, 1'b1, 2'b00, 1'b1, 1'b0, 25'h400};
        tbl[1] = '{"other_idx", 8'd1, 16,   1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 25'h400};
        tbl[2] = '{"short",     8'd0, 768,  1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b1, 25'h300};
        tbl[3] = '{"overflow",  8'd0, 1024, 1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 1'b1, 25'h400};
        tbl[4] = '{"reload",    8'd0, 1024, 1'b0, 1'b1, 1'b1, 2'b00, 1'b1, 1'b0, 25'h400};

        rst            = 1'b1;
        ioctl_download = 1'b0;
        ioctl_index    = 8'd0;
        ioctl_wr       = 1'b0;
        ioctl_addr     = 25'd0;
        ioctl_dout     = 8'd0;
        repeat (3) tick();
        check_reset_values("por");
        rst = 1'b0;
        repeat (2) tick();

        for (int k = 0; k < 4; k++) run_download(tbl[k]);

        // Reset cut into a transfer: writes after it are dropped until a new rise.
        ioctl_index    = 8'd0;
        ioctl_download = 1'b1;
        tick();
        for (int i = 0; i < 256; i++) wr_byte(25'(i), 1'b1);
        rst = 1'b1;
        tick();
        check_reset_values("midrst");
        rst = 1'b0;
        for (int i = 256; i < 272; i++) wr_byte(25'(i), 1'b0);
        check("midrst_count_after", {7'd0, byte_count}, 32'd0);
        ioctl_download = 1'b0;
        repeat (c_RH + 5) tick();
        check("midrst_core_reset_idle", {31'd0, core_reset}, 32'd1);
        check("midrst_rom_loaded_idle", {31'd0, rom_loaded}, 32'd0);
        check("midrst_sb_drained", sb_q.size(), 32'd0);

        run_download(tbl[4]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
